// File: rtl/spram_arb_if.sv
// spram_arb_if: request/grant/read-data bundle between two requesters and
// the spram_arb arbiter.
//   a_req/b_req      access request, held by the requester until granted
//   a_we/b_we        1 = write, 0 = read, qualified by the request
//   a_addr/b_addr    RAM address
//   a_data/b_data    write data
//   a_gnt/b_gnt      combinational grant for the current cycle
//   a_rvalid/b_rvalid  q carries this port's read result this cycle
//   q                shared RAM read data
// Modports: master = requester side, slave = arbiter side.
interface spram_arb_if #(
  parameter int DW = 8,
  parameter int AW = 11
);
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          a_gnt;
  logic          a_rvalid;
  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic          b_gnt;
  logic          b_rvalid;
  logic [DW-1:0] q;

  modport master (
    output a_req, a_we, a_addr, a_data, b_req, b_we, b_addr, b_data,
    input  a_gnt, a_rvalid, b_gnt, b_rvalid, q
  );

  modport slave (
    input  a_req, a_we, a_addr, a_data, b_req, b_we, b_addr, b_data,
    output a_gnt, a_rvalid, b_gnt, b_rvalid, q
  );
endinterface

// File: rtl/spram_arb.sv
// spram_arb: round-robin arbiter with bounded bursts sharing one
// single-port RAM between two requesters (A and B).
// Ports:
//   clk    clock, all logic on posedge
//   rst_n  asynchronous reset, active low
//   bus    spram_arb_if.slave: per-port req/we/addr/data in,
//          per-port gnt (combinational) and rvalid (registered) out, shared q
// Read latency is one cycle; writes are write-first and also update q.

// Single-port RAM, write-first, q holds its value when not selected.
module spram #(
  parameter int DW = 8,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          cs,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (cs) begin
      if (we) begin
        mem[addr] <= d;
        q         <= d;
      end else begin
        q <= mem[addr];
      end
    end
  end
endmodule

// Arbitration state
//   last  | cnt          | meaning
//   A/B   | 0            | idle last cycle; contention goes to the port not served last
//   A/B   | 1..MAX-1     | burst in progress on last; it keeps the grant under contention
//   A/B   | MAX_BURST    | burst exhausted; contention hands the grant to the other port
module spram_arb #(
  parameter int DW        = 8,
  parameter int AW        = 11,
  parameter int MAX_BURST = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  spram_arb_if.slave bus
);
  localparam int            CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  port_t         last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          a_rvalid_q, b_rvalid_q;
  logic          gnt_a, gnt_b;
  logic          pick_b;
  port_t         gnt_port;

  logic          ram_cs, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_d, ram_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= PORT_B;
      cnt_q      <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      a_rvalid_q <= gnt_a & ~bus.a_we;
      b_rvalid_q <= gnt_b & ~bus.b_we;
    end
  end

  always_comb begin
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    pick_b   = 1'b0;
    gnt_port = PORT_A;
    last_d   = last_q;
    cnt_d    = cnt_q;

    // An idle cycle (cnt==0) ends the burst, so the port not served last gets
    // priority; otherwise last keeps the grant until the burst count is used up.
    if ((cnt_q != '0) && (cnt_q < CNT_MAX)) begin
      pick_b = (last_q == PORT_B);
    end else begin
      pick_b = (last_q == PORT_A);
    end

    if (rst_n) begin
      if (bus.a_req && bus.b_req) begin
        gnt_a = ~pick_b;
        gnt_b = pick_b;
      end else begin
        gnt_a = bus.a_req;
        gnt_b = bus.b_req;
      end
    end

    gnt_port = gnt_b ? PORT_B : PORT_A;

    if (gnt_a || gnt_b) begin
      if (gnt_port == last_q) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      end else begin
        last_d = gnt_port;
        cnt_d  = CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  assign ram_cs   = gnt_a | gnt_b;
  assign ram_we   = gnt_b ? bus.b_we   : (gnt_a & bus.a_we);
  assign ram_addr = gnt_b ? bus.b_addr : bus.a_addr;
  assign ram_d    = gnt_b ? bus.b_data : bus.a_data;

  spram #(
    .DW(DW),
    .AW(AW)
  ) u_spram (
    .clk (clk),
    .cs  (ram_cs),
    .we  (ram_we),
    .addr(ram_addr),
    .d   (ram_d),
    .q   (ram_q)
  );

  assign bus.a_gnt    = gnt_a;
  assign bus.b_gnt    = gnt_b;
  assign bus.a_rvalid = a_rvalid_q;
  assign bus.b_rvalid = b_rvalid_q;
  assign bus.q        = ram_q;
endmodule

// File: tb/tb_spram_arb.sv
// tb_spram_arb: directed bench for spram_arb. Grants are checked per cycle
// against hand-derived sequences; every granted read pushes its expected
// port, data and arrival cycle into a scoreboard that a negedge monitor
// drains whenever the DUT raises a read-valid strobe. A second instance with
// MAX_BURST=1 checks strict alternation.
module tb_spram_arb;
  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  typedef struct {
    bit         port;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t sb[$];

  spram_arb_if #(.DW(8), .AW(4)) bus1 ();
  spram_arb_if #(.DW(8), .AW(4)) bus2 ();

  spram_arb #(.DW(8), .AW(4), .MAX_BURST(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  spram_arb #(.DW(8), .AW(4), .MAX_BURST(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor for the MAX_BURST=4 instance.
  always @(negedge clk) begin
    exp_t e;
    if (bus1.a_rvalid && bus1.b_rvalid) begin
      checks++;
      errors++;
      $display("FAIL rvalid_onehot actual=both required=one (cycle %0d)", cyc);
    end else if (bus1.a_rvalid || bus1.b_rvalid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid a=%0b b=%0b required=none (cycle %0d)",
                 bus1.a_rvalid, bus1.b_rvalid, cyc);
      end else begin
        e = sb.pop_front();
        if ((bus1.b_rvalid != e.port) || (bus1.q !== e.data) || (cyc != e.due)) begin
          errors++;
          $display("FAIL rdata actual port=%0d q=%0h cycle=%0d required port=%0d q=%0h cycle=%0d",
                   bus1.b_rvalid, bus1.q, cyc, e.port, e.data, e.due);
        end
      end
    end
  end

  // One cycle of stimulus on instance 1: drive, check grants mid-cycle,
  // record the expected read result, advance past the next edge.
  task automatic step(input bit ar, input bit aw, input logic [3:0] aa, input logic [7:0] ad,
                      input bit br, input bit bw, input logic [3:0] ba, input logic [7:0] bd,
                      input bit eag, input bit ebg, input logic [7:0] eq, input string nm);
    exp_t e;
    bus1.a_req  = ar;
    bus1.a_we   = aw;
    bus1.a_addr = aa;
    bus1.a_data = ad;
    bus1.b_req  = br;
    bus1.b_we   = bw;
    bus1.b_addr = ba;
    bus1.b_data = bd;
    @(negedge clk);
    chk({nm, "_a_gnt"}, {31'd0, bus1.a_gnt}, {31'd0, eag});
    chk({nm, "_b_gnt"}, {31'd0, bus1.b_gnt}, {31'd0, ebg});
    if ((eag && !aw) || (ebg && !bw)) begin
      e.port = ebg;
      e.data = eq;
      e.due  = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string nm);
    step(0, 0, 4'd0, 8'd0, 0, 0, 4'd0, 8'd0, 0, 0, 8'd0, nm);
  endtask

  bit contend_b [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
  bit join_b    [5]  = '{1, 1, 1, 1, 0};

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus1.a_req = 1'b1; bus1.a_we = 1'b0; bus1.a_addr = '0; bus1.a_data = '0;
    bus1.b_req = 1'b1; bus1.b_we = 1'b0; bus1.b_addr = '0; bus1.b_data = '0;
    bus2.a_req = 1'b0; bus2.a_we = 1'b0; bus2.a_addr = '0; bus2.a_data = '0;
    bus2.b_req = 1'b0; bus2.b_we = 1'b0; bus2.b_addr = '0; bus2.b_data = '0;

    // Held in reset with both requesting: no grants, no valids.
    @(posedge clk);
    #1;
    chk("rst_a_gnt", {31'd0, bus1.a_gnt}, 32'd0);
    chk("rst_b_gnt", {31'd0, bus1.b_gnt}, 32'd0);
    chk("rst_a_rvalid", {31'd0, bus1.a_rvalid}, 32'd0);
    chk("rst_b_rvalid", {31'd0, bus1.b_rvalid}, 32'd0);
    bus1.a_req = 1'b0;
    bus1.b_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Prefill: mem[i] = C0^i, single requester granted every cycle.
    for (int i = 0; i < 16; i++)
      step(1, 1, 4'(i), 8'(8'hC0 ^ i), 0, 0, 4'd0, 8'd0, 1, 0, 8'd0, "prefill");

    // Write then read the same address on A.
    step(1, 1, 4'd3, 8'h5A, 0, 0, 4'd0, 8'd0, 1, 0, 8'd0, "wr5a");
    step(1, 0, 4'd3, 8'h00, 0, 0, 4'd0, 8'd0, 1, 0, 8'h5A, "rd5a");
    idle("idle1");

    // Restart arbitration from reset, then contend continuously.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++)
      step(1, 0, 4'd1, 8'd0, 1, 0, 4'd2, 8'd0, !contend_b[i], contend_b[i],
           contend_b[i] ? 8'hC2 : 8'hC1, "contend");

    // A alone saturates its count; when B joins it wins at once and runs a full burst.
    for (int i = 0; i < 10; i++)
      step(1, 0, 4'd5, 8'd0, 0, 0, 4'd0, 8'd0, 1, 0, 8'hC5, "a_only");
    for (int i = 0; i < 5; i++)
      step(1, 0, 4'd5, 8'd0, 1, 0, 4'd2, 8'd0, !join_b[i], join_b[i],
           join_b[i] ? 8'hC2 : 8'hC5, "b_join");
    idle("idle2");

    // Leave last=B with no burst, so A wins the write/read collision.
    step(0, 0, 4'd0, 8'd0, 1, 0, 4'd2, 8'd0, 0, 1, 8'hC2, "b_only");
    idle("idle3");
    step(1, 1, 4'd7, 8'h11, 1, 0, 4'd7, 8'd0, 1, 0, 8'd0, "collide");
    step(0, 0, 4'd0, 8'd0, 1, 0, 4'd7, 8'd0, 0, 1, 8'h11, "b_rd7");
    idle("idle4");

    // Reset during a contended burst with a read result on q.
    step(1, 0, 4'd1, 8'd0, 1, 0, 4'd2, 8'd0, 1, 0, 8'hC1, "burst1");
    step(1, 0, 4'd1, 8'd0, 1, 0, 4'd2, 8'd0, 1, 0, 8'hC1, "burst2");
    chk("pre_rst_a_rvalid", {31'd0, bus1.a_rvalid}, 32'd1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_a_rvalid", {31'd0, bus1.a_rvalid}, 32'd0);
    chk("mid_rst_b_rvalid", {31'd0, bus1.b_rvalid}, 32'd0);
    chk("mid_rst_a_gnt", {31'd0, bus1.a_gnt}, 32'd0);
    chk("mid_rst_b_gnt", {31'd0, bus1.b_gnt}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 0, 4'd1, 8'd0, 1, 0, 4'd2, 8'd0, 1, 0, 8'hC1, "post_rst");
    step(0, 0, 4'd0, 8'd0, 1, 0, 4'd2, 8'd0, 0, 1, 8'hC2, "post_rst_b");
    step(1, 0, 4'd3, 8'd0, 0, 0, 4'd0, 8'd0, 1, 0, 8'h5A, "keep3");
    step(1, 0, 4'd7, 8'd0, 0, 0, 4'd0, 8'd0, 1, 0, 8'h11, "keep7");
    step(1, 0, 4'd0, 8'd0, 0, 0, 4'd0, 8'd0, 1, 0, 8'hC0, "keep0");
    idle("drain1");
    idle("drain2");
    chk("sb_empty", sb.size(), 32'd0);

    // MAX_BURST=1 instance: continuous contention alternates A,B,A,B.
    for (int i = 0; i < 8; i++) begin
      bus2.a_req  = 1'b1;
      bus2.a_addr = 4'd1;
      bus2.b_req  = 1'b1;
      bus2.b_addr = 4'd2;
      @(negedge clk);
      chk("alt_a_gnt", {31'd0, bus2.a_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("alt_b_gnt", {31'd0, bus2.b_gnt}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i > 0) begin
        chk("alt_a_rvalid", {31'd0, bus2.a_rvalid}, (i % 2 == 1) ? 32'd1 : 32'd0);
        chk("alt_b_rvalid", {31'd0, bus2.b_rvalid}, (i % 2 == 0) ? 32'd1 : 32'd0);
      end
      @(posedge clk);
      #1;
    end
    bus2.a_req = 1'b0;
    bus2.b_req = 1'b0;
    @(negedge clk);
    chk("alt_last_b_rvalid", {31'd0, bus2.b_rvalid}, 32'd1);
    chk("alt_last_a_rvalid", {31'd0, bus2.a_rvalid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
